levinson_kcalc: RTL and testbench
=================================

# levinson_kcalc

Reflection-coefficient front end of the Levinson-Durbin recursion. For order index i it reads the autocorrelation and current coefficients, accumulates the numerator (r[i] + Σ a[j]·r[i−j]), and drives the 64/33-bit divider with the negated sum and the prediction error. It holds those operands for the divider's fixed pipeline latency, then captures the quotient as k[i] for the coefficient-update stage.

## Interface
- ORDER, 10, maximum LPC order; legal iter is 1..ORDER
- A_FRAC, 16, fractional bits of a[j] and of k (Q15.16)
- DIV_LATENCY, 8, divider pipeline depth in clocks
- IW, $clog2(ORDER+1), index width
- clock  in  1  single clock, rising edge
- reset_n  in  1  asynchronous, active-low reset
- start  in  1  request pulse, sampled only in IDLE
- iter  in  IW  order index i for this request
- err  in  32 signed  prediction error E(i−1)
- r_addr  out  IW  autocorrelation read address; 1-cycle read latency
- r_data  in  32 signed  r[r_addr] from previous cycle
- a_addr  out  IW  coefficient read address; 1-cycle read latency
- a_data  in  32 signed  a[a_addr] from previous cycle, Q15.16
- numer  out  64 signed  divider numerator
- denom  out  33 signed  divider denominator
- div_quotient  in  32 signed  divider output
- busy  out  1  high in every state except IDLE
- k  out  32 signed  reflection coefficient, Q15.16
- k_valid  out  1  one-cycle pulse, k valid
- div_err  out  1  with k_valid: err ≤ 0, k forced to 0
- k_sat  out  1  with k_valid: k was clamped

## Operation
- States: IDLE → MAC → DRAIN → WAIT → DONE → IDLE.
- IDLE: if start && 1 ≤ iter ≤ ORDER, latch iter and err, clear acc, j=0, go to MAC. Out-of-range iter: request ignored, stay IDLE.
- start is ignored outside IDLE.
- MAC: lasts i cycles, j = 0..i−1.
  - Issue r_addr = i−j and a_addr = j.
  - Each cycle, accumulate the data returned for the previous j.
  - Term j=0 is r[i] sign-extended to 64 bits and shifted left by A_FRAC; a_data is ignored for this term.
  - Terms j ≥ 1 are 64-bit products a_data·r_data.
- DRAIN: 1 cycle. Accumulate the last term, then register:
  - numer = −acc
  - denom = {err[31], err}
- WAIT: DIV_LATENCY cycles. numer and denom are held stable. On the last edge of WAIT, k ← div_quotient.
- DONE: 1 cycle. k_valid=1, together with div_err and k_sat.
- Arithmetic:
  - acc is a 64-bit signed accumulator and wraps modulo 2^64; no overflow detection.
  - Divider truncates toward zero.
- err ≤ 0: sequence and latency are unchanged, but k=0 and div_err=1. denom is still driven; the quotient is discarded.
- numer/denom outside DRAIN..WAIT hold their last values; the divider computes continuously.

## Timing
- Reset: state=IDLE; all outputs 0, including r_addr, a_addr, numer, denom, k, k_valid, busy, div_err and k_sat.
- Asserting reset_n low mid-operation aborts immediately; no k_valid is produced for the aborted request.
- Start sampled at edge E0. busy is high from E0+ and stays high through DONE.
- k_valid is high in cycle i+DIV_LATENCY+2 after E0:
  - i=1: cycle 11
  - i=10: cycle 20
- The next start is accepted in the cycle after DONE, so back-to-back throughput is one request per i+DIV_LATENCY+3 cycles.
- k holds until the next DONE.

## Configuration
- LEVINSON_KSAT_EN defined: when k_valid is asserted, if |quotient| ≥ 2^A_FRAC, k is clamped to ±(2^A_FRAC−1) and k_sat=1.
- LEVINSON_KSAT_EN undefined: k is the raw quotient and k_sat is tied 0.

## Structure
- Shared levinson_pkg holds:
  - state enum (IDLE, MAC, DRAIN, WAIT, DONE)
  - DIV_LATENCY default, A_FRAC default
  - width constants: 64 numerator, 33 denominator, 32 data
- One sub-module, levinson_kcalc_mac: the 64-bit multiply-accumulate datapath, with clear, term-0 select and accumulate-enable. The FSM, latency counter and saturation stay in the top module.
- The divider is instantiated outside; this block connects only to its ports.

## Test plan
- i=1, r[1]=16384, err=32768 → numer=−2^30, denom=32768, k=−32768 (0xFFFF8000), k_valid in cycle 11, div_err=0.
- i=2, r[2]=0, r[1]=16384, a[1]=−32768, err=24576 → acc=−2^29, numer=2^29, k=21845 (truncated), k_valid in cycle 12.
- i=1, r[1]=65536, err=32768 → quotient −131072:
  - with LEVINSON_KSAT_EN: k=−65535, k_sat=1
  - without it: k=−131072, k_sat=0
- err=0, i=1 → k_valid in cycle 11, k=0, div_err=1.
- start during WAIT, and start with iter=0 or iter=ORDER+1 → all ignored, no extra k_valid.
- reset_n pulsed low in the 3rd WAIT cycle → all outputs 0 immediately, no k_valid; a following valid start completes with the nominal latency.

Source files
------------

// File: rtl/levinson_pkg.sv
// Shared types and defaults for the Levinson-Durbin reflection-coefficient front end.
// The optional k clamp, enabled by LEVINSON_KSAT_EN, uses sat_k() below.
package levinson_pkg;

    localparam int ORDER_DEF       = 10;
    localparam int A_FRAC_DEF      = 16;
    localparam int DIV_LATENCY_DEF = 8;
    localparam int NUM_W           = 64;
    localparam int DEN_W           = 33;
    localparam int DATA_W          = 32;

    typedef enum logic [2:0] {
        IDLE,
        MAC,
        DRAIN,
        WAIT,
        DONE
    } state_e;

    typedef struct packed {
        logic signed [DATA_W-1:0] k;
        logic                     sat;
    } ksat_t;

    // Clamp to +/-(2^frac - 1); -2^frac clamps as well, keeping the range symmetric.
    function automatic ksat_t sat_k(input logic signed [DATA_W-1:0] q, input int frac);
        logic signed [DATA_W-1:0] lim;
        lim       = $signed((DATA_W'(1) << frac) - DATA_W'(1));
        sat_k.k   = q;
        sat_k.sat = 1'b0;
        if (q > lim) begin
            sat_k.k   = lim;
            sat_k.sat = 1'b1;
        end else if (q < -lim) begin
            sat_k.k   = -lim;
            sat_k.sat = 1'b1;
        end
    endfunction

endpackage

// File: rtl/levinson_kcalc_mac.sv
// 64-bit multiply-accumulate for the reflection-coefficient numerator.
// Term 0 is r[i] aligned to the a[] fraction; later terms are a[j]*r[i-j].
module levinson_kcalc_mac
    import levinson_pkg::*;
#(
    parameter int A_FRAC = A_FRAC_DEF
) (
    input  logic                     clock_i,
    input  logic                     reset_n_i,
    input  logic                     clear_i,
    input  logic                     acc_en_i,
    input  logic                     term0_i,
    input  logic signed [DATA_W-1:0] r_data_i,
    input  logic signed [DATA_W-1:0] a_data_i,
    output logic signed [NUM_W-1:0]  sum_o
);

    logic signed [NUM_W-1:0] acc_q;
    logic signed [NUM_W-1:0] acc_d;
    logic signed [NUM_W-1:0] term;

    always_comb begin
        if (term0_i) begin
            term = {{(NUM_W-DATA_W){r_data_i[DATA_W-1]}}, r_data_i};
            term = term <<< A_FRAC;
        end else begin
            term = NUM_W'(a_data_i) * NUM_W'(r_data_i);
        end
        sum_o = acc_q + term;
        if (clear_i) begin
            acc_d = '0;
        end else if (acc_en_i) begin
            acc_d = sum_o;
        end else begin
            acc_d = acc_q;
        end
    end

    // NOTE: state registers update with <= so every flop samples pre-edge values.
    always_ff @(posedge clock_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end

endmodule

// File: rtl/levinson_kcalc.sv
// Levinson-Durbin k[i] front end: numerator MAC, divider operand hold, quotient capture.
// Define LEVINSON_KSAT_EN to clamp k to +/-(2^A_FRAC - 1) and report k_sat.
module levinson_kcalc
    import levinson_pkg::*;
#(
    parameter int ORDER       = ORDER_DEF,
    parameter int A_FRAC      = A_FRAC_DEF,
    parameter int DIV_LATENCY = DIV_LATENCY_DEF,
    parameter int IW          = $clog2(ORDER + 1)
) (
    input  logic                     clock_i,
    input  logic                     reset_n_i,
    input  logic                     start_i,
    input  logic [IW-1:0]            iter_i,
    input  logic signed [DATA_W-1:0] err_i,
    output logic [IW-1:0]            r_addr_o,
    input  logic signed [DATA_W-1:0] r_data_i,
    output logic [IW-1:0]            a_addr_o,
    input  logic signed [DATA_W-1:0] a_data_i,
    output logic signed [NUM_W-1:0]  numer_o,
    output logic signed [DEN_W-1:0]  denom_o,
    input  logic signed [DATA_W-1:0] div_quotient_i,
    output logic                     busy_o,
    output logic signed [DATA_W-1:0] k_o,
    output logic                     k_valid_o,
    output logic                     div_err_o,
    output logic                     k_sat_o
);

    localparam int            CW      = $clog2(DIV_LATENCY + 1);
    localparam logic [IW-1:0] ORDER_I = IW'(ORDER);

    state_e                   state_q, state_d;
    logic [IW-1:0]            iter_q, iter_d;
    logic [IW-1:0]            j_q, j_d;
    logic [IW-1:0]            r_addr_q, r_addr_d;
    logic [IW-1:0]            a_addr_q, a_addr_d;
    logic [CW-1:0]            cnt_q, cnt_d;
    logic signed [DATA_W-1:0] err_q, err_d;
    logic signed [NUM_W-1:0]  numer_q, numer_d;
    logic signed [DEN_W-1:0]  denom_q, denom_d;
    logic signed [DATA_W-1:0] k_q, k_d;
    logic                     div_err_q, div_err_d;
    logic                     k_sat_q, k_sat_d;

    logic                     mac_clear, mac_en, mac_term0;
    logic signed [NUM_W-1:0]  mac_sum;
`ifdef LEVINSON_KSAT_EN
    ksat_t                    ks;
`endif

    levinson_kcalc_mac #(.A_FRAC(A_FRAC)) u_mac (
        .clock_i   (clock_i),
        .reset_n_i (reset_n_i),
        .clear_i   (mac_clear),
        .acc_en_i  (mac_en),
        .term0_i   (mac_term0),
        .r_data_i  (r_data_i),
        .a_data_i  (a_data_i),
        .sum_o     (mac_sum)
    );

    // NOTE: every next-state signal gets its default first, so no path infers a latch.
    always_comb begin
        state_d   = state_q;
        iter_d    = iter_q;
        j_d       = j_q;
        r_addr_d  = r_addr_q;
        a_addr_d  = a_addr_q;
        cnt_d     = cnt_q;
        err_d     = err_q;
        numer_d   = numer_q;
        denom_d   = denom_q;
        k_d       = k_q;
        div_err_d = div_err_q;
        k_sat_d   = k_sat_q;
        mac_clear = 1'b0;
        mac_en    = 1'b0;
        mac_term0 = 1'b0;
`ifdef LEVINSON_KSAT_EN
        ks        = sat_k(div_quotient_i, A_FRAC);
`endif
        case (state_q)
            IDLE: begin
                if (start_i && iter_i != '0 && iter_i <= ORDER_I) begin
                    state_d   = MAC;
                    iter_d    = iter_i;
                    err_d     = err_i;
                    j_d       = '0;
                    r_addr_d  = iter_i;
                    a_addr_d  = '0;
                    mac_clear = 1'b1;
                end
            end
            MAC: begin
                // Read data lags the address by a cycle, so this cycle sums term j-1.
                mac_en    = (j_q != '0);
                mac_term0 = (j_q == IW'(1));
                if (j_q == iter_q - IW'(1)) begin
                    state_d = DRAIN;
                end else begin
                    j_d      = j_q + IW'(1);
                    r_addr_d = iter_q - j_q - IW'(1);
                    a_addr_d = j_q + IW'(1);
                end
            end
            DRAIN: begin
                mac_en    = 1'b1;
                mac_term0 = (iter_q == IW'(1));
                numer_d   = -mac_sum;
                denom_d   = {err_q[DATA_W-1], err_q};
                cnt_d     = CW'(DIV_LATENCY - 1);
                state_d   = WAIT;
            end
            WAIT: begin
                if (cnt_q == '0) begin
                    state_d = DONE;
                    if (err_q <= 32'sd0) begin
                        k_d       = '0;
                        div_err_d = 1'b1;
                        k_sat_d   = 1'b0;
                    end else begin
                        div_err_d = 1'b0;
`ifdef LEVINSON_KSAT_EN
                        k_d       = ks.k;
                        k_sat_d   = ks.sat;
`else
                        k_d       = div_quotient_i;
                        k_sat_d   = 1'b0;
`endif
                    end
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q   <= IDLE;
            iter_q    <= '0;
            j_q       <= '0;
            r_addr_q  <= '0;
            a_addr_q  <= '0;
            cnt_q     <= '0;
            err_q     <= '0;
            numer_q   <= '0;
            denom_q   <= '0;
            k_q       <= '0;
            div_err_q <= 1'b0;
            k_sat_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            iter_q    <= iter_d;
            j_q       <= j_d;
            r_addr_q  <= r_addr_d;
            a_addr_q  <= a_addr_d;
            cnt_q     <= cnt_d;
            err_q     <= err_d;
            numer_q   <= numer_d;
            denom_q   <= denom_d;
            k_q       <= k_d;
            div_err_q <= div_err_d;
            k_sat_q   <= k_sat_d;
        end
    end

    assign r_addr_o  = r_addr_q;
    assign a_addr_o  = a_addr_q;
    assign numer_o   = numer_q;
    assign denom_o   = denom_q;
    assign k_o       = k_q;
    assign busy_o    = (state_q != IDLE);
    assign k_valid_o = (state_q == DONE);
    assign div_err_o = k_valid_o & div_err_q;
    assign k_sat_o   = k_valid_o & k_sat_q;

endmodule

// File: tb/tb_levinson_kcalc.sv
// Scoreboard bench for levinson_kcalc: directed requests push expected k, a monitor checks each k_valid.
// Expected values for the clamp case follow LEVINSON_KSAT_EN.
module tb_levinson_kcalc;

    localparam int ORDER       = 10;
    localparam int A_FRAC      = 16;
    localparam int DIV_LATENCY = 8;
    localparam int IW          = $clog2(ORDER + 1);

    logic               clock = 1'b0;
    logic               reset_n = 1'b0;
    logic               start = 1'b0;
    logic [IW-1:0]      iter = '0;
    logic signed [31:0] err = '0;
    logic [IW-1:0]      r_addr, a_addr;
    logic signed [31:0] r_data = '0, a_data = '0;
    logic signed [63:0] numer;
    logic signed [32:0] denom;
    logic signed [31:0] div_quotient;
    logic               busy, k_valid, div_err, k_sat;
    logic signed [31:0] k;

    logic signed [31:0] r_mem [16];
    logic signed [31:0] a_mem [16];
    logic signed [31:0] qpipe [DIV_LATENCY-1];
    logic signed [31:0] q_now;

    typedef struct {
        logic signed [31:0] k;
        logic               de;
        logic               sat;
        int                 e0;
        int                 lat;
    } exp_t;

    exp_t sb[$];
    int   cyc = 0;
    int   n_checks = 0;
    int   n_pass = 0;

    levinson_kcalc #(.ORDER(ORDER), .A_FRAC(A_FRAC), .DIV_LATENCY(DIV_LATENCY), .IW(IW)) dut (
        .clock_i        (clock),
        .reset_n_i      (reset_n),
        .start_i        (start),
        .iter_i         (iter),
        .err_i          (err),
        .r_addr_o       (r_addr),
        .r_data_i       (r_data),
        .a_addr_o       (a_addr),
        .a_data_i       (a_data),
        .numer_o        (numer),
        .denom_o        (denom),
        .div_quotient_i (div_quotient),
        .busy_o         (busy),
        .k_o            (k),
        .k_valid_o      (k_valid),
        .div_err_o      (div_err),
        .k_sat_o        (k_sat)
    );

    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    // Memories with one-cycle read latency.
    always @(posedge clock) begin
        r_data <= r_mem[r_addr];
        a_data <= a_mem[a_addr];
    end

    // Divider model: truncating divide; the result settles in the last WAIT cycle.
    always_comb q_now = (denom == 0) ? 32'sd0 : 32'(numer / 64'(denom));
    always @(posedge clock) begin
        qpipe[0] <= q_now;
        for (int s = 1; s < DIV_LATENCY - 1; s++) qpipe[s] <= qpipe[s-1];
    end
    assign div_quotient = qpipe[DIV_LATENCY-2];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        else n_pass++;
    endtask

    task automatic issue(input int it, input logic signed [31:0] e, input bit push, input bit exp_busy,
                         input logic signed [31:0] ek, input bit ede, input bit esat);
        exp_t item;
        @(negedge clock);
        start = 1'b1;
        iter  = IW'(it);
        err   = e;
        if (push) begin
            item.k   = ek;
            item.de  = ede;
            item.sat = esat;
            item.e0  = cyc + 1;
            item.lat = it + DIV_LATENCY + 2;
            sb.push_back(item);
        end
        @(negedge clock);
        start = 1'b0;
        iter  = IW'(7);
        err   = 32'sh5A5A_1234;
        check("busy_after_start", 64'(busy), 64'(exp_busy));
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((sb.size() != 0 || busy) && n < 200) begin
            @(negedge clock);
            n++;
        end
        check("drain_before_timeout", 64'(sb.size()), 64'd0);
        @(negedge clock);
    endtask

    task automatic check_reset_outputs(input string name);
        check({name, "_numer"}, numer, 64'd0);
        check({name, "_denom"}, 64'(denom), 64'd0);
        check({name, "_misc"}, 64'({r_addr, a_addr, k, k_valid, busy, div_err, k_sat}), 64'd0);
    endtask

    // Monitor: every k_valid must match the oldest expected response.
    initial begin
        exp_t item;
        forever begin
            @(negedge clock);
            if (k_valid === 1'b1) begin
                if (sb.size() == 0) begin
                    check("spurious_k_valid", 64'(k_valid), 64'd0);
                end else begin
                    item = sb.pop_front();
                    check("k", k, item.k);
                    check("div_err", 64'(div_err), 64'(item.de));
                    check("k_sat", 64'(k_sat), 64'(item.sat));
                    check("k_valid_cycle", 64'(cyc - item.e0 + 1), 64'(item.lat));
                    check("busy_in_done", 64'(busy), 64'd1);
                end
            end
        end
    end

    initial begin
        logic signed [31:0] sat_k_exp;
        bit                 sat_exp;
`ifdef LEVINSON_KSAT_EN
        sat_k_exp = -32'sd65535;
        sat_exp   = 1'b1;
`else
        sat_k_exp = -32'sd131072;
        sat_exp   = 1'b0;
`endif
        for (int m = 0; m < 16; m++) begin
            r_mem[m] = 32'sd0;
            a_mem[m] = 32'sd0;
        end

        repeat (3) @(negedge clock);
        check_reset_outputs("reset");
        reset_n = 1'b1;

        // i=1: numer -2^30, denom 32768, k -32768; a start during WAIT is ignored.
        r_mem[1] = 32'sd16384;
        a_mem[0] = 32'sd777;
        issue(1, 32'sd32768, 1, 1, -32'sd32768, 0, 0);
        repeat (3) @(negedge clock);
        check("numer_hold", numer, -(64'sd1 <<< 30));
        check("denom_hold", 64'(denom), 64'd32768);
        start = 1'b1;
        iter  = IW'(2);
        @(negedge clock);
        start = 1'b0;
        wait_idle();
        check("k_hold", k, -64'sd32768);

        // i=2: a[0] and a[2] are garbage that must not be used.
        r_mem[2] = 32'sd0;
        r_mem[1] = 32'sd16384;
        a_mem[0] = 32'sd999;
        a_mem[1] = -32'sd32768;
        a_mem[2] = 32'sd5555;
        issue(2, 32'sd24576, 1, 1, 32'sd21845, 0, 0);
        wait_idle();
        check("numer_i2", numer, 64'sd536870912);

        // Quotient -131072: clamped or raw depending on the build.
        r_mem[1] = 32'sd65536;
        issue(1, 32'sd32768, 1, 1, sat_k_exp, 0, sat_exp);
        wait_idle();

        // err <= 0: k forced to 0 with div_err, same latency.
        r_mem[1] = 32'sd16384;
        issue(1, 32'sd0, 1, 1, 32'sd0, 1, 0);
        wait_idle();
        issue(2, -32'sd5, 1, 1, 32'sd0, 1, 0);
        wait_idle();

        // Out-of-range iter is ignored.
        issue(0, 32'sd32768, 0, 0, 32'sd0, 0, 0);
        issue(ORDER + 1, 32'sd32768, 0, 0, 32'sd0, 0, 0);
        repeat (15) @(negedge clock);

        // i=10: numer -(1045 << 16), err 2^20, k = -65.3125 truncated to -65.
        r_mem[10] = 32'sd1000;
        a_mem[0]  = 32'sd31;
        for (int m = 1; m <= 9; m++) begin
            r_mem[m] = 32'(m);
            a_mem[m] = 32'sd65536;
        end
        issue(10, 32'sd1048576, 1, 1, -32'sd65, 0, 0);
        wait_idle();

        // Reset in the 3rd WAIT cycle of an i=1 request aborts it.
        r_mem[1] = 32'sd16384;
        issue(1, 32'sd32768, 0, 1, 32'sd0, 0, 0);
        repeat (4) @(negedge clock);
        reset_n = 1'b0;
        #1;
        check_reset_outputs("abort");
        @(negedge clock);
        reset_n = 1'b1;
        issue(1, 32'sd32768, 1, 1, -32'sd32768, 0, 0);
        wait_idle();

        repeat (5) @(negedge clock);
        check("scoreboard_empty", 64'(sb.size()), 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
